// File: rtl/alu_arbiter_if.sv
// Bundle tying two requesters, the shared ALU and the response consumer to alu_arbiter.
// The arbiter uses the slave modport; the requester/ALU environment uses master.
interface alu_arbiter_if #(
    parameter int WIDTH = 32
);
    logic             req0_valid;
    logic             req1_valid;
    logic             req0_ready;
    logic             req1_ready;
    logic [1:0]       req0_aluop;
    logic [1:0]       req1_aluop;
    logic             req0_funct7;
    logic             req1_funct7;
    logic [2:0]       req0_funct3;
    logic [2:0]       req1_funct3;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;

    logic [3:0]       alu_operation;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [WIDTH-1:0] alu_result;
    logic             alu_zero;

    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_zero;
    logic             rsp_illegal;

    modport slave (
        input  req0_valid, req1_valid, req0_aluop, req1_aluop,
               req0_funct7, req1_funct7, req0_funct3, req1_funct3,
               req0_a, req0_b, req1_a, req1_b,
               alu_result, alu_zero, rsp_ready,
        output req0_ready, req1_ready, alu_operation, alu_a, alu_b,
               rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_illegal
    );

    modport master (
        output req0_valid, req1_valid, req0_aluop, req1_aluop,
               req0_funct7, req1_funct7, req0_funct3, req1_funct3,
               req0_a, req0_b, req1_a, req1_b,
               alu_result, alu_zero, rsp_ready,
        input  req0_ready, req1_ready, alu_operation, alu_a, alu_b,
               rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_illegal
    );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared ALU: arbitrate, decode, execute, hold response.
// Define ALU_ARB_RR_EN for round-robin arbitration; default is fixed priority to requester 0.
module alu_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           state_q;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             rsp_valid_q;
    logic             rsp_id_q;
    logic [WIDTH-1:0] rsp_result_q;
    logic             rsp_zero_q;
    logic             rsp_illegal_q;

    logic             grant1;
    logic             accept;
    logic [1:0]       sel_aluop;
    logic             sel_funct7;
    logic [2:0]       sel_funct3;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [3:0]       op_d;
    logic             illegal_d;

`ifdef ALU_ARB_RR_EN
    logic             ptr_q;

    // ptr_q remembers the last granted requester; on contention the other one wins.
    always_comb grant1 = bus.req1_valid && (!bus.req0_valid || !ptr_q);
`else
    always_comb grant1 = bus.req1_valid && !bus.req0_valid;
`endif

    assign accept         = rst_n && (state_q == IDLE) && (bus.req0_valid || bus.req1_valid);
    assign bus.req0_ready = accept && !grant1;
    assign bus.req1_ready = accept && grant1;

    assign sel_aluop  = grant1 ? bus.req1_aluop  : bus.req0_aluop;
    assign sel_funct7 = grant1 ? bus.req1_funct7 : bus.req0_funct7;
    assign sel_funct3 = grant1 ? bus.req1_funct3 : bus.req0_funct3;
    assign sel_a      = grant1 ? bus.req1_a      : bus.req0_a;
    assign sel_b      = grant1 ? bus.req1_b      : bus.req0_b;

    // Unmapped encodings fall back to add and are flagged illegal.
    always_comb begin
        op_d      = 4'b0010;
        illegal_d = 1'b0;
        case (sel_aluop)
            2'b00: op_d = 4'b0010;
            2'b01: op_d = 4'b0110;
            2'b10: begin
                case ({sel_funct7, sel_funct3})
                    4'b0000: op_d = 4'b0010;
                    4'b1000: op_d = 4'b0110;
                    4'b0111: op_d = 4'b0000;
                    4'b0110: op_d = 4'b0001;
                    default: illegal_d = 1'b1;
                endcase
            end
            default: illegal_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            op_q          <= 4'b0000;
            a_q           <= '0;
            b_q           <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_id_q      <= 1'b0;
            rsp_result_q  <= '0;
            rsp_zero_q    <= 1'b0;
            rsp_illegal_q <= 1'b0;
`ifdef ALU_ARB_RR_EN
            ptr_q         <= 1'b1;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        op_q          <= op_d;
                        a_q           <= sel_a;
                        b_q           <= sel_b;
                        rsp_id_q      <= grant1;
                        rsp_illegal_q <= illegal_d;
`ifdef ALU_ARB_RR_EN
                        ptr_q         <= grant1;
`endif
                        state_q       <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_result_q <= bus.alu_result;
                    rsp_zero_q   <= bus.alu_zero;
                    rsp_valid_q  <= 1'b1;
                    state_q      <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.alu_operation = op_q;
    assign bus.alu_a         = a_q;
    assign bus.alu_b         = b_q;
    assign bus.rsp_valid     = rsp_valid_q;
    assign bus.rsp_id        = rsp_id_q;
    assign bus.rsp_result    = rsp_result_q;
    assign bus.rsp_zero      = rsp_zero_q;
    assign bus.rsp_illegal   = rsp_illegal_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: directed and random transactions against a behavioural model.
// Expectations follow ALU_ARB_RR_EN when it is defined for the build.
module tb_alu_arbiter;
    localparam int WIDTH = 32;
`ifdef ALU_ARB_RR_EN
    localparam bit RR_MODE = 1'b1;
`else
    localparam bit RR_MODE = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    alu_arbiter_if #(.WIDTH(WIDTH)) bus ();
    alu_arbiter #(.WIDTH(WIDTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    // Behavioural stand-in for the shared combinational ALU.
    always_comb begin
        case (bus.alu_operation)
            4'b0000: bus.alu_result = bus.alu_a & bus.alu_b;
            4'b0001: bus.alu_result = bus.alu_a | bus.alu_b;
            4'b0110: bus.alu_result = bus.alu_a - bus.alu_b;
            default: bus.alu_result = bus.alu_a + bus.alu_b;
        endcase
    end
    assign bus.alu_zero = (bus.alu_result == '0);

    int checks = 0;
    int errors = 0;

    bit         pend [2];
    logic [1:0] mAluop [2];
    logic       mF7 [2];
    logic [2:0] mF3 [2];
    logic [31:0] mA [2];
    logic [31:0] mB [2];
    int         lastGrant;
    logic       dutGrant;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [4:0] refDecode(input logic [1:0] aluop, input logic f7, input logic [2:0] f3);
        if (aluop == 2'b00) return 5'b0_0010;
        if (aluop == 2'b01) return 5'b0_0110;
        if (aluop == 2'b10) begin
            if (!f7 && f3 == 3'd0) return 5'b0_0010;
            if (f7 && f3 == 3'd0)  return 5'b0_0110;
            if (!f7 && f3 == 3'd7) return 5'b0_0000;
            if (!f7 && f3 == 3'd6) return 5'b0_0001;
        end
        return 5'b1_0010;
    endfunction

    function automatic logic [31:0] refAlu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0110: return a - b;
            default: return a + b;
        endcase
    endfunction

    task automatic setReq(input int i, input logic [1:0] aluop, input logic f7, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] b);
        pend[i] = 1'b1;
        mAluop[i] = aluop;
        mF7[i] = f7;
        mF3[i] = f3;
        mA[i] = a;
        mB[i] = b;
    endtask

    task automatic randReq(input int i);
        logic [31:0] a;
        a = $urandom;
        // Bias toward equal operands now and then so zero results appear.
        setReq(i, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
               a, ($urandom_range(0, 3) == 0) ? a : $urandom);
    endtask

    task automatic applyStimulus();
        bus.req0_valid  = pend[0];
        bus.req0_aluop  = mAluop[0];
        bus.req0_funct7 = mF7[0];
        bus.req0_funct3 = mF3[0];
        bus.req0_a      = mA[0];
        bus.req0_b      = mB[0];
        bus.req1_valid  = pend[1];
        bus.req1_aluop  = mAluop[1];
        bus.req1_funct7 = mF7[1];
        bus.req1_funct3 = mF3[1];
        bus.req1_a      = mA[1];
        bus.req1_b      = mB[1];
    endtask

    task automatic checkRsp(input int g, input logic [4:0] dec, input logic [31:0] res);
        checkOutput("rsp_valid", 64'(bus.rsp_valid), 64'(1'b1));
        checkOutput("rsp_id", 64'(bus.rsp_id), 64'(g));
        checkOutput("rsp_result", 64'(bus.rsp_result), 64'(res));
        checkOutput("rsp_zero", 64'(bus.rsp_zero), 64'(res == 32'd0));
        checkOutput("rsp_illegal", 64'(bus.rsp_illegal), 64'(dec[4]));
        checkOutput("resp_ready0_low", 64'(bus.req0_ready), 64'(1'b0));
        checkOutput("resp_ready1_low", 64'(bus.req1_ready), 64'(1'b0));
    endtask

    // One full transaction starting in IDLE, #1 after a rising edge, with at least one request pending.
    task automatic doTxn(input int stall);
        int g;
        logic [4:0] dec;
        logic [31:0] res;
        applyStimulus();
        @(negedge clk);
        if (pend[0] && pend[1]) g = RR_MODE ? ((lastGrant == 0) ? 1 : 0) : 0;
        else g = pend[1] ? 1 : 0;
        checkOutput("grant_ready0", 64'(bus.req0_ready), 64'(g == 0));
        checkOutput("grant_ready1", 64'(bus.req1_ready), 64'(g == 1));
        checkOutput("idle_rsp_valid", 64'(bus.rsp_valid), 64'(1'b0));
        dutGrant = bus.req1_ready;
        lastGrant = g;
        dec = refDecode(mAluop[g], mF7[g], mF3[g]);
        res = refAlu(dec[3:0], mA[g], mB[g]);
        @(posedge clk);
        #1;
        pend[g] = 1'b0;
        applyStimulus();
        bus.rsp_ready = (stall == 0);
        @(negedge clk);
        checkOutput("exec_alu_operation", 64'(bus.alu_operation), 64'(dec[3:0]));
        checkOutput("exec_alu_a", 64'(bus.alu_a), 64'(mA[g]));
        checkOutput("exec_alu_b", 64'(bus.alu_b), 64'(mB[g]));
        checkOutput("exec_ready_low", 64'({bus.req0_ready, bus.req1_ready}), 64'(2'b00));
        checkOutput("exec_rsp_valid", 64'(bus.rsp_valid), 64'(1'b0));
        @(posedge clk);
        @(negedge clk);
        checkRsp(g, dec, res);
        for (int j = 0; j < stall; j++) begin
            @(posedge clk);
            #1;
            if (j == stall - 1) bus.rsp_ready = 1'b1;
            @(negedge clk);
            checkRsp(g, dec, res);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic applyReset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_ready0", 64'(bus.req0_ready), 64'(1'b0));
        checkOutput("reset_ready1", 64'(bus.req1_ready), 64'(1'b0));
        checkOutput("reset_rsp_valid", 64'(bus.rsp_valid), 64'(1'b0));
        checkOutput("reset_alu_operation", 64'(bus.alu_operation), 64'(4'b0000));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        lastGrant = 1;
    endtask

    initial begin
        int expSeq [4];
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 2; i++) setReq(i, 2'b00, 1'b0, 3'd0, 32'd0, 32'd0);
        pend[1] = 1'b0;
        applyStimulus();
        applyReset();

        setReq(0, 2'b10, 1'b0, 3'b000, 32'd5, 32'd7);
        doTxn(0);
        setReq(1, 2'b01, 1'b0, 3'b000, 32'd9, 32'd9);
        doTxn(0);
        setReq(0, 2'b11, 1'b0, 3'b000, 32'd3, 32'd4);
        doTxn(1);
        setReq(1, 2'b10, 1'b1, 3'b111, 32'd20, 32'd6);
        doTxn(0);
        setReq(0, 2'b10, 1'b0, 3'b110, 32'hF0F0_0000, 32'h0000_0F0F);
        doTxn(4);

        // Both requesters stay valid continuously from reset.
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        applyStimulus();
        applyReset();
        expSeq = RR_MODE ? '{0, 1, 0, 1} : '{0, 0, 0, 0};
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 2; i++) if (!pend[i]) randReq(i);
            doTxn(0);
            checkOutput("contention_grant", 64'(dutGrant), 64'(expSeq[r]));
        end

        // Abort an operation with a one-edge reset during EXEC.
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        setReq(0, 2'b10, 1'b1, 3'b000, 32'd100, 32'd1);
        applyStimulus();
        @(negedge clk);
        checkOutput("abort_accept", 64'(bus.req0_ready), 64'(1'b1));
        @(posedge clk);
        #1;
        pend[0] = 1'b0;
        applyStimulus();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        lastGrant = 1;
        @(negedge clk);
        checkOutput("abort_rsp_valid", 64'(bus.rsp_valid), 64'(1'b0));
        checkOutput("abort_rsp_id", 64'(bus.rsp_id), 64'(1'b0));
        checkOutput("abort_rsp_result", 64'(bus.rsp_result), 64'(32'd0));
        checkOutput("abort_rsp_zero", 64'(bus.rsp_zero), 64'(1'b0));
        checkOutput("abort_rsp_illegal", 64'(bus.rsp_illegal), 64'(1'b0));
        checkOutput("abort_alu_operation", 64'(bus.alu_operation), 64'(4'b0000));
        checkOutput("abort_alu_a", 64'(bus.alu_a), 64'(32'd0));
        checkOutput("abort_alu_b", 64'(bus.alu_b), 64'(32'd0));
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checkOutput("abort_no_rsp", 64'(bus.rsp_valid), 64'(1'b0));
        end
        @(posedge clk);
        #1;

        for (int r = 0; r < 40; r++) begin
            for (int i = 0; i < 2; i++) if (!pend[i] && $urandom_range(0, 1) == 1) randReq(i);
            if (!pend[0] && !pend[1]) randReq(int'($urandom_range(0, 1)));
            doTxn(int'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
